// File: rtl/cla_pkg.sv
// Shared types and carry-lookahead equations for the 4-bit CLA groups.
// Imported by the group cell and the pipelined adder top level.
package cla_pkg;

   localparam int GROUP_W = 4;

   typedef struct packed {
      logic [GROUP_W-1:0] sum;
      logic               p;
      logic               g;
      logic               c_out;
   } cla_grp_t;

   // Flattened lookahead: every carry is a two-level function of p, g and c_in.
   function automatic logic [GROUP_W:0] cla_carries(input logic [GROUP_W-1:0] p,
                                                    input logic [GROUP_W-1:0] g,
                                                    input logic c_in);
      logic [GROUP_W:0] c;
      c[0] = c_in;
      c[1] = g[0] | (p[0] & c_in);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c_in);
      return c;
   endfunction

   function automatic logic group_generate(input logic [GROUP_W-1:0] p,
                                           input logic [GROUP_W-1:0] g);
      return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
   endfunction

   function automatic logic group_carry(input logic grp_p, input logic grp_g, input logic c_in);
      return grp_g | (grp_p & c_in);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_group.sv
// Combinational 4-bit carry-lookahead group: sum, group P/G, carry out and
// the carry into bit 3 (needed for signed overflow on the top group).
module cla_group_4
   import cla_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       p,
   output logic       g,
   output logic       c_out,
   output logic       c3
);

   logic [3:0] bit_p;
   logic [3:0] bit_g;
   logic [4:0] c;
   cla_grp_t   res;

   assign bit_p = a ^ b;
   assign bit_g = a & b;
   assign c     = cla_carries(bit_p, bit_g, c_in);

   assign res.sum   = bit_p ^ c[3:0];
   assign res.p     = &bit_p;
   assign res.g     = group_generate(bit_p, bit_g);
   assign res.c_out = c[4];

   assign sum   = res.sum;
   assign p     = res.p;
   assign g     = res.g;
   assign c_out = res.c_out;
   assign c3    = c[3];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one 4-bit CLA group per stage, carry registered
// between stages, operands skewed in and sum bits deskewed out.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero
);

   localparam int STAGES = WIDTH / GROUP_W;

   logic adv;

   // Whole pipeline advances together; it only stalls when a result is stuck.
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   for (genvar k = 0; k < STAGES; k++) begin : st
      logic [WIDTH-1:0] a_src, b_src, s_src, s_next;
      logic             c_src, v_src;
      logic [WIDTH-1:0] a_r, b_r, s_r;
      logic             cy_r, v_r;
      cla_grp_t         grp;
      logic             grp_c3;

      if (k == 0) begin : src
         assign a_src = a;
         assign b_src = b ^ {WIDTH{sub}};
         assign c_src = sub | c_in;
         assign s_src = '0;
         assign v_src = in_valid;
      end else begin : src
         assign a_src = st[k-1].a_r;
         assign b_src = st[k-1].b_r;
         assign c_src = st[k-1].cy_r;
         assign s_src = st[k-1].s_r;
         assign v_src = st[k-1].v_r;
      end

      cla_group_4 u_grp (
         .a     (a_src[k*GROUP_W +: GROUP_W]),
         .b     (b_src[k*GROUP_W +: GROUP_W]),
         .c_in  (c_src),
         .sum   (grp.sum),
         .p     (grp.p),
         .g     (grp.g),
         .c_out (grp.c_out),
         .c3    (grp_c3)
      );

      always_comb begin
         // NOTE: give every always_comb output a full default before partial updates, or a latch is inferred.
         s_next                     = s_src;
         s_next[k*GROUP_W +: GROUP_W] = grp.sum;
         assert (grp.c_out == group_carry(grp.p, grp.g, c_src));
      end

      // NOTE: datapath registers are reset too, so outputs read 0 after reset rather than stale data.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            s_r  <= '0;
            cy_r <= 1'b0;
            v_r  <= 1'b0;
         end else if (adv) begin
            // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
            v_r <= v_src;
            if (v_src) begin
               a_r  <= a_src;
               b_r  <= b_src;
               s_r  <= s_next;
               cy_r <= grp.c_out;
            end
         end
      end

      if (k == STAGES - 1) begin : flg
         logic ovf_r, zero_r;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_r  <= 1'b0;
               zero_r <= 1'b0;
            end else if (adv && v_src) begin
               ovf_r  <= grp_c3 ^ grp.c_out;
               zero_r <= (s_next == '0);
            end
         end
      end
   end

   assign out_valid = st[STAGES-1].v_r;
   assign sum       = st[STAGES-1].s_r;
   assign c_out     = st[STAGES-1].cy_r;
   assign overflow  = st[STAGES-1].flg.ovf_r;
   assign zero      = st[STAGES-1].flg.zero_r;

endmodule
